// File: rtl/kws_wb_pkg.sv
// Shared types and widths for the KWS Wishbone initiator and its command FIFO.
package kws_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;
    localparam int CMD_W = 1 + WB_SW + WB_AW + WB_DW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic             we;
        logic [WB_SW-1:0] sel;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } cmd_t;

endpackage

// File: rtl/kws_cmd_fifo.sv
// Synchronous command FIFO with a registered head word, valid whenever !empty.
module kws_cmd_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + (AW + 1)'(1);
        if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
        // The head register always holds the oldest entry still stored.
        if (do_pop) begin
            if (count_q > (AW + 1)'(1)) dout_d = mem_q[rd_ptr_q + AW'(1)];
            else if (do_push)           dout_d = din;
        end else if (do_push && count_q == '0) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/kws_wb_master.sv
// Wishbone classic initiator: queued commands issued one at a time, one response each.
module kws_wb_master
    import kws_wb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [WB_SW-1:0] cmd_sel,
    input  logic [WB_AW-1:0] cmd_addr,
    input  logic [WB_DW-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic [WB_DW-1:0] wbm_dat_i,
    input  logic             wbm_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    cmd_t cmd_in, cmd_head;
    logic fifo_full, fifo_empty, fifo_pop;

    assign cmd_in = '{we: cmd_we, sel: cmd_sel, adr: cmd_addr, dat: cmd_data};

    kws_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (cmd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = cmd_head.we;
                    sel_d    = cmd_head.sel;
                    adr_d    = cmd_head.adr;
                    dat_d    = cmd_head.dat;
                    cyc_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack wins over a timeout landing on the same edge.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : wbm_dat_i;
                    state_d     = ST_RESP;
                end else if (cnt_d == CNT_MAX) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_kws_wb_master.sv
// Scoreboard bench for kws_wb_master with a Wishbone responder model.
module tb_kws_wb_master;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
    logic [31:0] rsp_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    kws_wb_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] data; logic err; } rsp_t;
    typedef struct { logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat; int len; } bus_t;
    rsp_t rsp_q[$];
    bus_t bus_q[$];

    // Responder: acks after ack_dly sampled strobe cycles, returns an address-derived word.
    function automatic logic [31:0] rd_value(input logic [31:0] a);
        if (a == 32'h3000_0004) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h0101};
    endfunction

    logic        ack_r = 1'b0, inj_ack = 1'b0;
    logic [31:0] rdat = '0;
    bit          ack_en = 1'b1;
    int          ack_dly = 1;
    int          wcnt = 0;
    bit          rr_rand = 1'b0;

    assign wbm_ack_i = ack_r | inj_ack;
    assign wbm_dat_i = rdat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !ack_r) begin
            if (ack_en && wcnt + 1 >= ack_dly) begin
                ack_r <= 1'b1;
                rdat  <= rd_value(wbm_adr_o);
                wcnt  <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            if (!wbm_cyc_o) wcnt <= 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: occupancy model, bus protocol and response scoreboard.
    int          fifo_cnt = 0, low_run = 100, hi_len = 0, cur_len = 0;
    bit          pend_acc = 0, prev_cyc = 0, prev_ack_cyc = 0, hold_v = 0, saw_full = 0;
    logic [31:0] hold_d = '0;
    logic        hold_e = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fifo_cnt = 0; low_run = 100; hi_len = 0; pend_acc = 0;
            prev_cyc = 0; prev_ack_cyc = 0; hold_v = 0;
        end else begin
            if (pend_acc) fifo_cnt++;
            if (wbm_cyc_o && !prev_cyc) fifo_cnt--;
            chk("cmd_ready", 32'(cmd_ready), 32'(fifo_cnt < DEPTH));
            if (!cmd_ready) saw_full = 1;
            pend_acc = cmd_valid && cmd_ready;

            chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
            if (prev_ack_cyc) chk("stb_after_ack", 32'(wbm_stb_o), 32'd0);
            prev_ack_cyc = wbm_ack_i && wbm_cyc_o;

            if (wbm_cyc_o && !prev_cyc) begin
                chk("cyc_gap_ge2", 32'(low_run >= 2), 32'd1);
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got cycle at %h expected none", wbm_adr_o);
                    cur_len = 0;
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(wbm_we_o), 32'(b.we));
                    chk("bus_sel", 32'(wbm_sel_o), 32'(b.sel));
                    chk("bus_adr", wbm_adr_o, b.adr);
                    if (b.we) chk("bus_dat", wbm_dat_o, b.dat);
                    cur_len = b.len;
                end
                hi_len = 0;
            end
            if (wbm_cyc_o) begin
                hi_len++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (!wbm_cyc_o && prev_cyc) chk("stb_len", 32'(hi_len), 32'(cur_len));
            prev_cyc = wbm_cyc_o;

            if (rsp_valid) begin
                chk("no_cyc_in_resp", 32'(wbm_cyc_o), 32'd0);
                if (hold_v) begin
                    chk("rsp_data_stable", rsp_data, hold_d);
                    chk("rsp_err_stable", 32'(rsp_err), 32'(hold_e));
                end
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: got %h err %b expected none", rsp_data, rsp_err);
                    end else begin
                        rsp_t r;
                        r = rsp_q.pop_front();
                        chk("rsp_data", rsp_data, r.data);
                        chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    end
                end
            end
            hold_v = rsp_valid && !rsp_ready;
            hold_d = rsp_data;
            hold_e = rsp_err;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; expectations are queued just before the accepting edge.
    task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
        int   n;
        bit   ok;
        rsp_t r;
        bus_t b;
        n = 0; ok = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_addr = adr; cmd_data = dat;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1; else n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got cmd_ready 0 expected 1");
            cmd_valid = 1'b0;
            return;
        end
        r.err  = !ack_en;
        r.data = (!ack_en || we) ? 32'h0 : rd_value(adr);
        rsp_q.push_back(r);
        b.we = we; b.sel = sel; b.adr = adr; b.dat = dat;
        b.len = ack_en ? ack_dly + 1 : TMO;
        bus_q.push_back(b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < max), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        align();

        // Single write with latency checks.
        send(1'b1, 4'hF, 32'h3000_0000, 32'h0000_0001);
        @(negedge clk); chk("lat_cyc_n", 32'(wbm_cyc_o), 32'd0);
        @(negedge clk); chk("lat_cyc_n1", 32'(wbm_cyc_o), 32'd1);
        chk("lat_we", 32'(wbm_we_o), 32'd1);
        @(negedge clk); chk("lat_rsp_n2", 32'(rsp_valid), 32'd0);
        @(negedge clk); chk("lat_rsp_n3", 32'(rsp_valid), 32'd1);
        chk("lat_cyc_n3", 32'(wbm_cyc_o), 32'd0);
        wait_drain(50);

        // Read returning DEAD_BEEF.
        align();
        send(1'b0, 4'hF, 32'h3000_0004, 32'h0);
        wait_drain(50);

        // Timeout, then a late ack that must be ignored.
        ack_en = 0;
        align();
        send(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        wait_drain(100);
        ack_en = 1;
        align(); align();
        inj_ack = 1'b1;
        align();
        inj_ack = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("late_ack_no_rsp", 32'(seen), 32'd0);
        chk("late_ack_idle", 32'(busy), 32'd0);

        // Six back-to-back commands fill the FIFO.
        saw_full = 0;
        align();
        for (int i = 0; i < 6; i++)
            send(1'(i & 1), 4'(i + 1), 32'h3000_0100 + 32'(i * 4), $urandom);
        wait_drain(300);
        chk("fifo_filled", 32'(saw_full), 32'd1);

        // Response back-pressure with a second command queued.
        rsp_ready = 1'b0;
        align();
        send(1'b0, 4'h3, 32'h3000_0200, 32'h0);
        send(1'b1, 4'hC, 32'h3000_0204, 32'h1234_5678);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
        chk("bp_no_cyc", 32'(wbm_cyc_o), 32'd0);
        align();
        rsp_ready = 1'b1;
        wait_drain(100);

        // Reset while a cycle is on the bus.
        ack_en = 0;
        align();
        send(1'b0, 4'hF, 32'h3000_0300, 32'h0);
        n = 0;
        while (!wbm_cyc_o && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_in_bus", 32'(wbm_cyc_o), 32'd1);
        align(); align();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_q.delete();
        bus_q.delete();
        ack_en = 1;
        align(); align();
        rst_n = 1'b1;
        align();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        send(1'b1, 4'hF, 32'h3000_0000, 32'h0000_0002);
        wait_drain(50);

        // Randomized traffic with random response back-pressure.
        for (int ph = 0; ph < 3; ph++) begin
            ack_dly = $urandom_range(1, 3);
            rr_rand = 1'b1;
            align();
            for (int i = 0; i < 15; i++) begin
                send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     {20'h30000, 10'($urandom), 2'b00}, $urandom);
                repeat ($urandom_range(0, 2)) align();
            end
            wait_drain(2000);
            rr_rand = 1'b0;
            rsp_ready = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
